// File: rtl/nn_result_scoreboard_if.sv
// Handshake bundle between the network-result source and the result scoreboard.
// The master drives the sample and control inputs; the slave returns the scores and the mismatch log.
interface nn_result_scoreboard_if #(
   parameter int CNT_W = 10,
   parameter int OUT_W = 8
);
   logic             start;
   logic             sample_valid;
   logic [OUT_W-1:0] test_out;
   logic [OUT_W-1:0] label;
   logic             nn_done;
   logic             log_pop;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] correct_cnt;
   logic             last_match;
   logic [6:0]       acc_pct;
   logic             acc_valid;
   logic             busy;
   logic [CNT_W-1:0] log_idx;
   logic             log_empty;
   logic             log_overflow;

   modport master (
      output start, sample_valid, test_out, label, nn_done, log_pop,
      input  sample_cnt, correct_cnt, last_match, acc_pct, acc_valid, busy,
             log_idx, log_empty, log_overflow
   );

   modport slave (
      input  start, sample_valid, test_out, label, nn_done, log_pop,
      output sample_cnt, correct_cnt, last_match, acc_pct, acc_valid, busy,
             log_idx, log_empty, log_overflow
   );
endinterface

// File: rtl/nn_result_scoreboard.sv
// Scores classified samples against their labels, logs the indices of mismatches in a FIFO,
// and computes the integer accuracy percentage with a restoring divider at end of test.
module nn_result_scoreboard #(
   parameter int N_SAMPLES = 750,
   parameter int CNT_W     = 10,
   parameter int OUT_W     = 8,
   parameter int LOG_DEPTH = 16
) (
   input logic               clk,
   input logic               rst,
   nn_result_scoreboard_if.slave sb
);
   localparam int DIV_W  = CNT_W + 7;
   localparam int PTR_W  = $clog2(LOG_DEPTH);
   localparam int STEP_W = $clog2(DIV_W + 1);
   localparam logic [CNT_W-1:0] N_MAX    = N_SAMPLES[CNT_W-1:0];
   localparam logic [PTR_W:0]   LOG_FULL = LOG_DEPTH[PTR_W:0];

   typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   sample_cnt;
   logic [CNT_W-1:0]   correct_cnt;
   logic               last_match;
   logic [6:0]         acc_pct;
   logic               acc_valid;
   logic               busy;
   logic               log_overflow;
   logic [CNT_W-1:0]   log_mem [LOG_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     log_cnt;
   logic [CNT_W:0]     rem;
   logic [DIV_W-1:0]   dq;
   logic [STEP_W-1:0]  div_step;

   logic               match;
   logic               score;
   logic               full;
   logic               pop;
   logic               push;
   logic               push_ok;
   logic [CNT_W-1:0]   correct_nxt;
   logic [CNT_W:0]     rem_shift;
   logic [CNT_W:0]     rem_nxt;
   logic               ge;
   logic [DIV_W-1:0]   dq_nxt;

   // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
   always_comb begin
      match       = (sb.test_out == sb.label);
      score       = !sb.start && (state == RUN) && sb.sample_valid && (sample_cnt < N_MAX);
      full        = (log_cnt == LOG_FULL);
      pop         = !sb.start && sb.log_pop && (log_cnt != '0);
      push        = score && !match;
      push_ok     = push && (!full || pop);
      correct_nxt = correct_cnt + {{(CNT_W-1){1'b0}}, score && match};
      // dq shifts the dividend out of its top while quotient bits enter at the bottom
      rem_shift   = {rem[CNT_W-1:0], dq[DIV_W-1]};
      ge          = (rem_shift >= {1'b0, sample_cnt});
      rem_nxt     = ge ? rem_shift - {1'b0, sample_cnt} : rem_shift;
      dq_nxt      = {dq[DIV_W-2:0], ge};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sample_cnt   <= '0;
         correct_cnt  <= '0;
         last_match   <= 1'b0;
         acc_pct      <= '0;
         acc_valid    <= 1'b0;
         busy         <= 1'b0;
         log_overflow <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         log_cnt      <= '0;
         rem          <= '0;
         dq           <= '0;
         div_step     <= '0;
      end else if (sb.start) begin
         state        <= RUN;
         sample_cnt   <= '0;
         correct_cnt  <= '0;
         last_match   <= 1'b0;
         acc_pct      <= '0;
         acc_valid    <= 1'b0;
         busy         <= 1'b1;
         log_overflow <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         log_cnt      <= '0;
         rem          <= '0;
         dq           <= '0;
         div_step     <= '0;
      end else begin
         if (pop)                 rd_ptr       <= rd_ptr + 1'b1;
         if (push_ok)             wr_ptr       <= wr_ptr + 1'b1;
         if (push && full && !pop) log_overflow <= 1'b1;
         case ({push_ok, pop})
            2'b10:   log_cnt <= log_cnt + 1'b1;
            2'b01:   log_cnt <= log_cnt - 1'b1;
            default: ;
         endcase

         case (state)
            RUN: begin
               if (score) begin
                  sample_cnt  <= sample_cnt + 1'b1;
                  correct_cnt <= correct_nxt;
                  last_match  <= match;
               end
               // a sample arriving with nn_done is already folded into correct_nxt
               if (sb.nn_done) begin
                  state    <= DIV;
                  rem      <= '0;
                  dq       <= DIV_W'(correct_nxt) * DIV_W'(100);
                  div_step <= STEP_W'(DIV_W);
               end
            end
            DIV: begin
               if (sample_cnt == '0) begin
                  acc_pct   <= '0;
                  state     <= DONE;
                  busy      <= 1'b0;
                  acc_valid <= 1'b1;
               end else begin
                  rem      <= rem_nxt;
                  dq       <= dq_nxt;
                  div_step <= div_step - 1'b1;
                  if (div_step == STEP_W'(1)) begin
                     acc_pct   <= dq_nxt[6:0];
                     state     <= DONE;
                     busy      <= 1'b0;
                     acc_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the log storage has no reset; validity is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) log_mem[wr_ptr] <= sample_cnt;
   end

   assign sb.sample_cnt   = sample_cnt;
   assign sb.correct_cnt  = correct_cnt;
   assign sb.last_match   = last_match;
   assign sb.acc_pct      = acc_pct;
   assign sb.acc_valid    = acc_valid;
   assign sb.busy         = busy;
   assign sb.log_empty    = (log_cnt == '0);
   assign sb.log_idx      = (log_cnt == '0) ? '0 : log_mem[rd_ptr];
   assign sb.log_overflow = log_overflow;
endmodule

// File: tb/tb_nn_result_scoreboard.sv
// Self-checking bench: a table of scored samples plus hand-written corner sequences, with a
// queue-based scoreboard for the mismatch log and the end-of-test accuracy.
module tb_nn_result_scoreboard;
   localparam int N  = 750;
   localparam int CW = 10;
   localparam int OW = 8;
   localparam int LD = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nn_result_scoreboard_if #(.CNT_W(CW), .OUT_W(OW)) sb_if ();

   nn_result_scoreboard #(
      .N_SAMPLES(N), .CNT_W(CW), .OUT_W(OW), .LOG_DEPTH(LD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sb (sb_if.slave)
   );

   typedef struct {
      int o;
      int l;
      int e_cnt;
      int e_corr;
      int e_match;
   } vec_t;

   int  n_checks = 0;
   int  n_fail   = 0;
   int  exp_log[$];
   int  exp_acc[$];
   int  m_cnt, m_correct, m_last;
   bit  m_run, m_ovf;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sb_if.start        = 1'b0;
      sb_if.sample_valid = 1'b0;
      sb_if.test_out     = '0;
      sb_if.label        = '0;
      sb_if.nn_done      = 1'b0;
      sb_if.log_pop      = 1'b0;
   endtask

   task automatic model_clear();
      m_cnt     = 0;
      m_correct = 0;
      m_last    = 0;
      m_ovf     = 0;
      exp_log.delete();
      exp_acc.delete();
   endtask

   task automatic do_start();
      sb_if.start = 1'b1;
      tick();
      sb_if.start = 1'b0;
      model_clear();
      m_run = 1;
   endtask

   // One clock of stimulus; the reference model is advanced with the values present before the edge.
   task automatic step(input bit sv, input int o, input int l, input bit nd, input bit pop);
      bit full;
      bit popped;
      sb_if.sample_valid = sv;
      sb_if.test_out     = OW'(o);
      sb_if.label        = OW'(l);
      sb_if.nn_done      = nd;
      sb_if.log_pop      = pop;
      full   = (exp_log.size() == LD);
      popped = pop && (exp_log.size() > 0);
      if (popped) check("log_head", int'(sb_if.log_idx), exp_log.pop_front());
      if (m_run && sv && m_cnt < N) begin
         if (o != l) begin
            if (!full || popped) exp_log.push_back(m_cnt);
            else m_ovf = 1;
         end else begin
            m_correct++;
         end
         m_last = (o == l) ? 1 : 0;
         m_cnt++;
      end
      if (m_run && nd) begin
         m_run = 0;
         exp_acc.push_back((m_cnt == 0) ? 0 : (m_correct * 100) / m_cnt);
      end
      tick();
      idle_inputs();
   endtask

   task automatic check_model(input string tag);
      check({tag, ".sample_cnt"},   int'(sb_if.sample_cnt),   m_cnt);
      check({tag, ".correct_cnt"},  int'(sb_if.correct_cnt),  m_correct);
      check({tag, ".last_match"},   int'(sb_if.last_match),   m_last);
      check({tag, ".log_overflow"}, int'(sb_if.log_overflow), int'(m_ovf));
      check({tag, ".log_empty"},    int'(sb_if.log_empty),    (exp_log.size() == 0) ? 1 : 0);
   endtask

   task automatic wait_acc(input string tag, input int exp_lat);
      int n = 0;
      while (!sb_if.acc_valid && n < 40) begin
         tick();
         n++;
      end
      check({tag, ".acc_latency"}, n, exp_lat);
      if (exp_acc.size() > 0) check({tag, ".acc_pct_model"}, int'(sb_if.acc_pct), exp_acc.pop_front());
      check({tag, ".busy_done"}, int'(sb_if.busy), 0);
   endtask

   task automatic drain_log(input string tag);
      int guard = 0;
      while (exp_log.size() > 0 && guard < 40) begin
         step(0, 0, 0, 0, 1);
         guard++;
      end
      check({tag, ".drained_empty"}, int'(sb_if.log_empty), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[4];
      tbl[0] = '{3, 3, 1, 1, 1};
      tbl[1] = '{5, 5, 2, 2, 1};
      tbl[2] = '{1, 2, 3, 2, 0};
      tbl[3] = '{7, 7, 4, 3, 1};

      idle_inputs();
      model_clear();
      m_run = 0;
      rst   = 1'b1;
      #12;
      check("reset.sample_cnt", int'(sb_if.sample_cnt), 0);
      check("reset.acc_valid",  int'(sb_if.acc_valid),  0);
      check("reset.busy",       int'(sb_if.busy),       0);
      check("reset.log_empty",  int'(sb_if.log_empty),  1);
      rst = 1'b0;
      tick();

      // Four scored samples from the table, then end of test: 3 of 4 correct
      do_start();
      check("t1.busy", int'(sb_if.busy), 1);
      for (int i = 0; i < 4; i++) begin
         step(1, tbl[i].o, tbl[i].l, 0, 0);
         check($sformatf("t1.v%0d.sample_cnt", i),  int'(sb_if.sample_cnt),  tbl[i].e_cnt);
         check($sformatf("t1.v%0d.correct_cnt", i), int'(sb_if.correct_cnt), tbl[i].e_corr);
         check($sformatf("t1.v%0d.last_match", i),  int'(sb_if.last_match),  tbl[i].e_match);
      end
      step(0, 0, 0, 1, 0);
      check("t1.acc_valid_early", int'(sb_if.acc_valid), 0);
      wait_acc("t1", 17);
      check("t1.acc_pct", int'(sb_if.acc_pct), 75);
      check("t1.log_idx", int'(sb_if.log_idx), 2);
      check_model("t1");

      // Six samples with mismatches at indices 1 and 5
      do_start();
      check("t2.acc_valid_cleared", int'(sb_if.acc_valid), 0);
      for (int i = 0; i < 6; i++) step(1, i, (i == 1 || i == 5) ? i + 7 : i, 0, 0);
      step(0, 0, 0, 1, 0);
      wait_acc("t2", 17);
      check("t2.acc_pct", int'(sb_if.acc_pct), 66);
      check("t2.log_idx_first", int'(sb_if.log_idx), 1);
      step(0, 0, 0, 0, 1);
      check("t2.log_idx_second", int'(sb_if.log_idx), 5);
      step(0, 0, 0, 0, 1);
      check("t2.log_empty", int'(sb_if.log_empty), 1);
      step(0, 0, 0, 0, 1);
      check("t2.extra_pop_empty", int'(sb_if.log_empty), 1);
      check("t2.acc_hold", int'(sb_if.acc_valid), 1);
      check_model("t2");

      // 18 mismatches without pops: log keeps 0..15 and flags the drops
      do_start();
      for (int i = 0; i < 18; i++) step(1, i, i + 1, 0, 0);
      check("t3.overflow", int'(sb_if.log_overflow), 1);
      check("t3.head", int'(sb_if.log_idx), 0);
      check_model("t3");
      drain_log("t3");

      // 17th mismatch coincides with a pop while full: no overflow
      do_start();
      for (int i = 0; i < 16; i++) step(1, 1, 2, 0, 0);
      step(1, 1, 2, 0, 1);
      check("t3b.overflow", int'(sb_if.log_overflow), 0);
      check("t3b.head", int'(sb_if.log_idx), 1);
      check_model("t3b");
      drain_log("t3b");

      // End of test with no samples, then nn_done together with a matching sample
      do_start();
      step(0, 0, 0, 1, 0);
      wait_acc("t4a", 1);
      check("t4a.acc_pct", int'(sb_if.acc_pct), 0);
      check("t4a.sample_cnt", int'(sb_if.sample_cnt), 0);
      do_start();
      step(1, 4, 4, 1, 0);
      wait_acc("t4b", 17);
      check("t4b.sample_cnt", int'(sb_if.sample_cnt), 1);
      check("t4b.acc_pct", int'(sb_if.acc_pct), 100);

      // Saturation: 750 matches and a 751st (mismatching) sample that must be ignored
      do_start();
      for (int i = 0; i < N; i++) step(1, i % 200, i % 200, 0, 0);
      step(1, 1, 9, 0, 0);
      check("t5.sample_cnt", int'(sb_if.sample_cnt), 750);
      check("t5.correct_cnt", int'(sb_if.correct_cnt), 750);
      check("t5.log_empty", int'(sb_if.log_empty), 1);
      step(0, 0, 0, 1, 0);
      wait_acc("t5", 17);
      check("t5.acc_pct", int'(sb_if.acc_pct), 100);

      // Asynchronous reset in the middle of the divide
      do_start();
      step(1, 2, 2, 0, 0);
      step(1, 2, 3, 0, 0);
      step(1, 6, 6, 0, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) tick();
      check("t6.busy_in_div", int'(sb_if.busy), 1);
      rst = 1'b1;
      #1;
      check("t6.rst.sample_cnt",  int'(sb_if.sample_cnt),   0);
      check("t6.rst.correct_cnt", int'(sb_if.correct_cnt),  0);
      check("t6.rst.last_match",  int'(sb_if.last_match),   0);
      check("t6.rst.busy",        int'(sb_if.busy),         0);
      check("t6.rst.acc_valid",   int'(sb_if.acc_valid),    0);
      check("t6.rst.acc_pct",     int'(sb_if.acc_pct),      0);
      check("t6.rst.log_empty",   int'(sb_if.log_empty),    1);
      check("t6.rst.log_idx",     int'(sb_if.log_idx),      0);
      #2;
      rst = 1'b0;
      model_clear();
      m_run = 0;
      tick();
      step(1, 1, 1, 0, 0);
      check_model("t6.idle_ignore");

      // start during RUN after three samples restarts indexing from zero
      do_start();
      step(1, 1, 1, 0, 0);
      step(1, 1, 2, 0, 0);
      step(1, 3, 3, 0, 0);
      check("t7.pre.sample_cnt", int'(sb_if.sample_cnt), 3);
      do_start();
      check_model("t7.cleared");
      check("t7.busy", int'(sb_if.busy), 1);
      step(1, 5, 6, 0, 0);
      check("t7.head_index", int'(sb_if.log_idx), 0);
      check_model("t7.resumed");
      drain_log("t7");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/nn_result_scoreboard.md
# nn_result_scoreboard

Downstream consumer of the neural-network top's `test_out` / `batch_done` / `done` outputs. The block scores each classified test sample against its expected label and counts total and correct samples. It logs the indices of misclassified samples in a small FIFO and computes integer accuracy percentage with an iterative divider once the test set finishes. The results feed on-chip status readout and the verification bench.

## Interface
Parameters:
- `N_SAMPLES`, 750: samples in the test set; sample counter saturates here.
- `CNT_W`, 10: counter width; must hold `N_SAMPLES`.
- `OUT_W`, 8: width of `test_out` and `label`.
- `LOG_DEPTH`, 16: mismatch-log FIFO depth (power of two).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse; clears all results and enters RUN.
- `sample_valid`  in  1: one-cycle pulse per classified sample (driven from `batch_done`).
- `test_out`  in  OUT_W: network prediction; sampled when `sample_valid`=1.
- `label`  in  OUT_W: expected class for the same sample; sampled with `test_out`.
- `nn_done`  in  1: end of test set (driven from `done`).
- `sample_cnt`  out  CNT_W: samples scored.
- `correct_cnt`  out  CNT_W: samples with `test_out == label`.
- `last_match`  out  1: match flag of the most recently scored sample.
- `acc_pct`  out  7: floor(correct_cnt*100/sample_cnt); 0..100.
- `acc_valid`  out  1: high in DONE.
- `busy`  out  1: high in RUN or DIV.
- `log_idx`  out  CNT_W: head of the mismatch log (first-word fall-through).
- `log_empty`  out  1: log holds no entries.
- `log_pop`  in  1: consume head entry.
- `log_overflow`  out  1: sticky; a mismatch was dropped because the log was full.

## Operation
- States: IDLE, RUN, DIV, DONE. All outputs reset to 0, except `log_empty`=1. State resets to IDLE.
- `start` in any state: clears counters, `acc_pct`, `last_match`, log pointers, `log_overflow`, divider. Next state is RUN. `start` has priority over every other input that cycle.
- RUN, on `sample_valid` with `sample_cnt < N_SAMPLES`:
  - `sample_cnt` increments.
  - `last_match` is set to `(test_out == label)`.
  - On match, `correct_cnt` increments.
  - On mismatch, the pre-increment `sample_cnt` value (zero-based index) is pushed to the log.
- RUN, on `sample_valid` with `sample_cnt == N_SAMPLES`: ignored, no counter or log change.
- `sample_valid` outside RUN is ignored.
- RUN, on `nn_done`: a `sample_valid` in the same cycle is scored first. Next state is DIV.
- DIV:
  - If `sample_cnt == 0`: `acc_pct`=0 and the next state is DONE.
  - Otherwise a restoring divider runs with dividend `correct_cnt*100` (CNT_W+7 bits) and divisor `sample_cnt`, producing one quotient bit per cycle for CNT_W+7 cycles. It then loads `acc_pct` from the low 7 quotient bits and the next state is DONE.
- DONE: `acc_valid`=1 and all results hold until `start` or `rst`.
- Mismatch log:
  - Push when not full: entry stored.
  - Push when full without a simultaneous pop: entry dropped and `log_overflow` set.
  - Push and pop in the same cycle when full: both happen and no overflow.
  - `log_pop` when empty: ignored.
  - Pop is allowed in any state.
  - Pointers wrap modulo LOG_DEPTH. A count register distinguishes full from empty.

## Timing
- Counters, `last_match` and the log update on the edge that samples `sample_valid`. The new values are visible the following cycle.
- `log_idx` and `log_empty` reflect a push one cycle after the push edge. `log_pop` advances the head on its edge.
- `busy` rises the cycle after `start`.
- `acc_valid` rises CNT_W+7 cycles (17 with defaults) after the edge that samples `nn_done`. With `sample_cnt`=0 it rises 1 cycle after that edge.
- `rst` takes effect asynchronously: all outputs go to their reset values immediately, in any state including mid-divide. Operation resumes only after deassertion and `start`.

## Test plan
- `start`; 4 samples with `test_out`/`label` = 3/3, 5/5, 1/2, 7/7; `nn_done` -> `sample_cnt`=4, `correct_cnt`=3, `acc_pct`=75, `acc_valid` 17 cycles after `nn_done`; `last_match`=1.
- 6 samples, mismatches at indices 1 and 5 -> after DONE, `log_idx`=1; pop -> `log_idx`=5; pop -> `log_empty`=1; extra pop leaves the log unchanged.
- 18 consecutive mismatches with no pops -> log holds 0..15, `log_overflow`=1. Repeat with a pop in the same cycle as the 17th push -> no overflow.
- `nn_done` right after `start` with no samples -> `acc_pct`=0, `acc_valid` one cycle later. `nn_done` in the same cycle as a matching `sample_valid` -> that sample is counted.
- 750 matching samples plus a 751st `sample_valid` -> `sample_cnt`=750, `correct_cnt`=750, `acc_pct`=100.
- Assert `rst` in the middle of DIV -> all outputs zero immediately, `log_empty`=1. Separately, `start` during RUN after 3 samples -> counters clear, RUN continues from index 0.
